// File: rtl/telemetre_pkg.sv
// Shared types and 50 MHz board timing defaults for the telemeter sequencer.
package telemetre_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StTrig,
    StWaitEcho,
    StMeasure,
    StDone,
    StHoldoff
  } state_e;

  // Defaults for a 50 MHz Clk.
  localparam int unsigned TrigCyclesDef    = 500;      // 10 us
  localparam int unsigned CmCyclesDef      = 2900;     // 58 us per cm
  localparam int unsigned TimeoutCyclesDef = 1500000;  // 30 ms
  localparam int unsigned PeriodCyclesDef  = 3000000;  // 60 ms
  localparam int unsigned MaxCmDef         = 400;

endpackage

// File: rtl/echo_sync.sv
// Echo input synchroniser: two flops into the Clk domain, then an edge register
// producing one-cycle rise/fall pulses. An edge is acted on 3 cycles after the pin moves.
module echo_sync (
  input  logic Clk,
  input  logic nReset,
  input  logic echo_i,
  output logic rise_o,
  output logic fall_o
);

  logic sync1_q, sync2_q, prev_q;

  // Synchroniser chain and edge history, synchronous active-low reset
  always_ff @(posedge Clk) begin
    if (!nReset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= echo_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  // Edge pulses from the synchronised level and its one-cycle-old copy
  always_comb begin
    rise_o = sync2_q & ~prev_q;
    fall_o = ~sync2_q & prev_q;
  end

endmodule

// File: rtl/telemetre_sequencer.sv
// Ultrasonic telemeter measurement sequencer: trigger, echo timing, per-cm count
// ticks for the external digit counters, counter clear and display latch strobe.
// Optional feature macro TELEMETRE_BIN_DIST_EN: keep a binary copy of the last
// distance on Distance; without it Distance is tied to 0.
module telemetre_sequencer
  import telemetre_pkg::*;
#(
  parameter int unsigned TRIG_CYCLES    = TrigCyclesDef,
  parameter int unsigned CM_CYCLES      = CmCyclesDef,
  parameter int unsigned TIMEOUT_CYCLES = TimeoutCyclesDef,
  parameter int unsigned PERIOD_CYCLES  = PeriodCyclesDef,
  parameter int unsigned MAX_CM         = MaxCmDef
) (
  input  logic                         Clk,
  input  logic                         nReset,
  input  logic                         Start,
  input  logic                         Echo,
  output logic                         Trig,
  output logic                         CntTick,
  output logic                         CntClr_n,
  output logic                         Latch,
  output logic                         Busy,
  output logic                         Timeout,
  output logic                         Overrange,
  output logic [$clog2(MAX_CM+1)-1:0]  Distance
);

  localparam int unsigned PeriodW = $clog2(PERIOD_CYCLES);
  localparam int unsigned TmoW    = $clog2(TIMEOUT_CYCLES);
  localparam int unsigned PreW    = $clog2(CM_CYCLES);
  localparam int unsigned CmW     = $clog2(MAX_CM + 1);

  localparam logic [PeriodW-1:0] TrigLast  = PeriodW'(TRIG_CYCLES - 1);
  localparam logic [PeriodW-1:0] PeriodMax = PeriodW'(PERIOD_CYCLES - 1);
  // HOLDOFF is left two cycles early so CLEAR ends exactly PERIOD_CYCLES after
  // the previous TRIG entry.
  localparam logic [PeriodW-1:0] HoldLast  = PeriodW'(PERIOD_CYCLES - 3);
  localparam logic [TmoW-1:0]    TmoLast   = TmoW'(TIMEOUT_CYCLES - 1);
  localparam logic [PreW-1:0]    PreLast   = PreW'(CM_CYCLES - 1);
  localparam logic [CmW-1:0]     CmMax     = CmW'(MAX_CM);
  localparam logic [CmW-1:0]     CmLast    = CmW'(MAX_CM - 1);

  state_e             state_q;
  logic               trig_q, tick_q, clr_n_q, latch_q, busy_q, timeout_q, over_q;
  logic               clr_ph_q;
  logic [PeriodW-1:0] period_cnt_q;
  logic [TmoW-1:0]    tmo_cnt_q;
  logic [PreW-1:0]    pre_cnt_q;
  logic [CmW-1:0]     cm_cnt_q;

  logic echo_rise, echo_fall;
  logic tmo_hit, go_done;

  echo_sync u_echo_sync (
    .Clk    (Clk),
    .nReset (nReset),
    .echo_i (Echo),
    .rise_o (echo_rise),
    .fall_o (echo_fall)
  );

  // Shot completion: no echo in time, echo fell, or echo too long
  always_comb begin
    tmo_hit = (tmo_cnt_q == TmoLast);
    go_done = ((state_q == StWaitEcho) && !echo_rise && tmo_hit) ||
              ((state_q == StMeasure) && (echo_fall || tmo_hit));
  end

  // Sequencer FSM with registered outputs
  always_ff @(posedge Clk) begin
    if (!nReset) begin
      state_q      <= StIdle;
      trig_q       <= 1'b0;
      tick_q       <= 1'b0;
      clr_n_q      <= 1'b1;
      latch_q      <= 1'b0;
      busy_q       <= 1'b0;
      timeout_q    <= 1'b0;
      over_q       <= 1'b0;
      clr_ph_q     <= 1'b0;
      period_cnt_q <= '0;
      tmo_cnt_q    <= '0;
      pre_cnt_q    <= '0;
      cm_cnt_q     <= '0;
    end else begin
      tick_q  <= 1'b0;
      latch_q <= 1'b0;
      // Time since TRIG entry; saturates so a long shot cannot wrap it
      if (period_cnt_q != PeriodMax) period_cnt_q <= period_cnt_q + 1'b1;

      unique case (state_q)
        StIdle: begin
          if (Start) begin
            state_q   <= StClear;
            busy_q    <= 1'b1;
            clr_n_q   <= 1'b0;
            clr_ph_q  <= 1'b0;
            timeout_q <= 1'b0;
            over_q    <= 1'b0;
            cm_cnt_q  <= '0;
          end
        end
        StClear: begin
          if (!clr_ph_q) begin
            // Counters clear synchronously, so they need a tick while clear is low
            clr_ph_q <= 1'b1;
            tick_q   <= 1'b1;
          end else begin
            clr_n_q      <= 1'b1;
            trig_q       <= 1'b1;
            period_cnt_q <= '0;
            state_q      <= StTrig;
          end
        end
        StTrig: begin
          if (period_cnt_q == TrigLast) begin
            trig_q    <= 1'b0;
            tmo_cnt_q <= '0;
            state_q   <= StWaitEcho;
          end
        end
        StWaitEcho: begin
          tmo_cnt_q <= tmo_cnt_q + 1'b1;
          if (echo_rise) begin
            tmo_cnt_q <= '0;
            pre_cnt_q <= '0;
            state_q   <= StMeasure;
          end else if (go_done) begin
            timeout_q <= 1'b1;
            latch_q   <= 1'b1;
            state_q   <= StDone;
          end
        end
        StMeasure: begin
          if (go_done) begin
            // A fall coinciding with a prescaler wrap truncates that centimetre
            if (!echo_fall) timeout_q <= 1'b1;
            latch_q <= 1'b1;
            state_q <= StDone;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
            if (pre_cnt_q == PreLast) begin
              pre_cnt_q <= '0;
              if (cm_cnt_q != CmMax) begin
                tick_q   <= 1'b1;
                cm_cnt_q <= cm_cnt_q + 1'b1;
                if (cm_cnt_q == CmLast) over_q <= 1'b1;
              end
            end else begin
              pre_cnt_q <= pre_cnt_q + 1'b1;
            end
          end
        end
        StDone: begin
          state_q <= StHoldoff;
        end
        StHoldoff: begin
          if (period_cnt_q >= HoldLast) begin
            if (Start) begin
              state_q   <= StClear;
              clr_n_q   <= 1'b0;
              clr_ph_q  <= 1'b0;
              timeout_q <= 1'b0;
              over_q    <= 1'b0;
              cm_cnt_q  <= '0;
            end else begin
              state_q <= StIdle;
              busy_q  <= 1'b0;
            end
          end
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Drive ports from the registered outputs
  always_comb begin
    Trig      = trig_q;
    CntTick   = tick_q;
    CntClr_n  = clr_n_q;
    Latch     = latch_q;
    Busy      = busy_q;
    Timeout   = timeout_q;
    Overrange = over_q;
  end

`ifdef TELEMETRE_BIN_DIST_EN
  logic [CmW-1:0] dist_q;

  // Capture the cm count on the edge that raises Latch; hold until the next one
  always_ff @(posedge Clk) begin
    if (!nReset) begin
      dist_q <= '0;
    end else if (go_done) begin
      dist_q <= cm_cnt_q;
    end
  end

  assign Distance = dist_q;
`else
  assign Distance = '0;
`endif

endmodule

// File: tb/tb_telemetre_sequencer.sv
// Directed bench for telemetre_sequencer with reduced timing parameters.
module tb_telemetre_sequencer;

  localparam int unsigned TrigC   = 5;
  localparam int unsigned CmC     = 4;
  localparam int unsigned TmoC    = 200;
  localparam int unsigned PeriodC = 400;
  localparam int unsigned MaxCm   = 20;
  localparam int unsigned DistW   = $clog2(MaxCm + 1);
`ifdef TELEMETRE_BIN_DIST_EN
  localparam bit DistEn = 1'b1;
`else
  localparam bit DistEn = 1'b0;
`endif

  logic             Clk = 1'b0;
  logic             nReset, Start, Echo;
  logic             Trig, CntTick, CntClr_n, Latch, Busy, Timeout, Overrange;
  logic [DistW-1:0] Distance;

  int n_vec  = 0;
  int n_fail = 0;

  // Monitor state, sampled 1 time unit after each rising edge
  int cyc = 0, n_tick = 0, n_latch = 0, n_rise = 0;
  int last_rise = 0, prev_rise = 0, fall_cyc = 0, latch_cyc = 0, trig_len = 0;
  logic trig_prev = 1'b0;

  int t_base, l_snap, r_snap;

  telemetre_sequencer #(
    .TRIG_CYCLES    (TrigC),
    .CM_CYCLES      (CmC),
    .TIMEOUT_CYCLES (TmoC),
    .PERIOD_CYCLES  (PeriodC),
    .MAX_CM         (MaxCm)
  ) dut (
    .Clk       (Clk),
    .nReset    (nReset),
    .Start     (Start),
    .Echo      (Echo),
    .Trig      (Trig),
    .CntTick   (CntTick),
    .CntClr_n  (CntClr_n),
    .Latch     (Latch),
    .Busy      (Busy),
    .Timeout   (Timeout),
    .Overrange (Overrange),
    .Distance  (Distance)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) begin
    #1;
    cyc++;
    if (CntTick === 1'b1) n_tick++;
    if (Latch === 1'b1) begin
      n_latch++;
      latch_cyc = cyc;
    end
    if (Trig === 1'b1 && trig_prev == 1'b0) begin
      prev_rise = last_rise;
      last_rise = cyc;
      n_rise++;
    end
    if (Trig === 1'b0 && trig_prev == 1'b1) begin
      fall_cyc = cyc;
      trig_len = cyc - last_rise;
    end
    trig_prev = (Trig === 1'b1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_trig"}, 32'(Trig), 0);
    check({tag, "_tick"}, 32'(CntTick), 0);
    check({tag, "_clrn"}, 32'(CntClr_n), 1);
    check({tag, "_latch"}, 32'(Latch), 0);
    check({tag, "_busy"}, 32'(Busy), 0);
    check({tag, "_tmo"}, 32'(Timeout), 0);
    check({tag, "_ovr"}, 32'(Overrange), 0);
    check({tag, "_dist"}, 32'(Distance), 0);
  endtask

  // Bounded wait at falling edges for sel (0 Trig, 1 Latch, 2 Busy) to reach val
  task automatic wait_sig(input int sel, input logic val, input int limit, input string tag);
    int n;
    logic s;
    n = 0;
    s = (sel == 0) ? Trig : (sel == 1) ? Latch : Busy;
    while (s !== val && n < limit) begin
      @(negedge Clk);
      n++;
      s = (sel == 0) ? Trig : (sel == 1) ? Latch : Busy;
    end
    check(tag, 32'(s), 32'(val));
  endtask

  // Three falling edges after a clear starts: clear low twice, tick on the second
  task automatic check_clear(input string tag);
    @(negedge Clk);
    check({tag, "_c1_clrn"}, 32'(CntClr_n), 0);
    check({tag, "_c1_tick"}, 32'(CntTick), 0);
    check({tag, "_c1_busy"}, 32'(Busy), 1);
    @(negedge Clk);
    check({tag, "_c2_clrn"}, 32'(CntClr_n), 0);
    check({tag, "_c2_tick"}, 32'(CntTick), 1);
    @(negedge Clk);
    check({tag, "_c3_clrn"}, 32'(CntClr_n), 1);
    check({tag, "_c3_tick"}, 32'(CntTick), 0);
    check({tag, "_c3_trig"}, 32'(Trig), 1);
  endtask

  // Echo pin falls now; Latch must appear on the third falling edge after
  task automatic echo_fall_latch(input string tag);
    Echo = 1'b0;
    @(negedge Clk);
    check({tag, "_l1"}, 32'(Latch), 0);
    @(negedge Clk);
    check({tag, "_l2"}, 32'(Latch), 0);
    @(negedge Clk);
    check({tag, "_l3"}, 32'(Latch), 1);
  endtask

  initial begin
    nReset = 1'b0;
    Start  = 1'b0;
    Echo   = 1'b0;
    repeat (3) @(negedge Clk);
    check_reset("rst");
    nReset = 1'b1;
    @(negedge Clk);
    check("idle_busy", 32'(Busy), 0);

    // Shot 1: echo 10 cycles after Trig falls, 50 cycles long -> 12 cm
    Start = 1'b1;
    check_clear("s1");
    wait_sig(0, 1'b0, 20, "s1_trig_fall");
    check("s1_trig_len", trig_len, TrigC);
    t_base = n_tick;
    repeat (9) @(negedge Clk);
    Echo = 1'b1;
    repeat (50) @(negedge Clk);
    echo_fall_latch("s1");
    check("s1_ticks", n_tick - t_base, 12);
    check("s1_tmo", 32'(Timeout), 0);
    check("s1_ovr", 32'(Overrange), 0);
    check("s1_dist", 32'(Distance), DistEn ? 12 : 0);
    check("s1_busy", 32'(Busy), 1);
    @(negedge Clk);
    check("s1_latch_1cyc", 32'(Latch), 0);

    // Shot 2: no echo -> timeout 200 cycles after Trig falls
    wait_sig(0, 1'b1, 420, "s2_trig_rise");
    wait_sig(0, 1'b0, 20, "s2_trig_fall");
    check("s2_period", last_rise - prev_rise, PeriodC);
    t_base = n_tick;
    wait_sig(1, 1'b1, 250, "s2_latch");
    check("s2_latch_delay", latch_cyc - fall_cyc, TmoC);
    check("s2_tmo", 32'(Timeout), 1);
    check("s2_ovr", 32'(Overrange), 0);
    check("s2_ticks", n_tick - t_base, 0);
    check("s2_dist", 32'(Distance), 0);

    // Shot 3: echo 120 cycles -> saturates at 20 cm
    wait_sig(0, 1'b1, 420, "s3_trig_rise");
    check("s3_tmo_cleared", 32'(Timeout), 0);
    wait_sig(0, 1'b0, 20, "s3_trig_fall");
    check("s3_period", last_rise - prev_rise, PeriodC);
    t_base = n_tick;
    repeat (3) @(negedge Clk);
    Echo = 1'b1;
    repeat (120) @(negedge Clk);
    echo_fall_latch("s3");
    check("s3_ticks", n_tick - t_base, MaxCm);
    check("s3_ovr", 32'(Overrange), 1);
    check("s3_tmo", 32'(Timeout), 0);
    check("s3_dist", 32'(Distance), DistEn ? MaxCm : 0);
    // Echo goes high in HOLDOFF and stays high into the next shot
    repeat (5) @(negedge Clk);
    Echo = 1'b1;

    // Shot 4: echo already high -> no rise seen -> timeout, no ticks
    wait_sig(0, 1'b1, 420, "s4_trig_rise");
    check("s4_ovr_cleared", 32'(Overrange), 0);
    wait_sig(0, 1'b0, 20, "s4_trig_fall");
    check("s4_period", last_rise - prev_rise, PeriodC);
    t_base = n_tick;
    wait_sig(1, 1'b1, 250, "s4_latch");
    check("s4_latch_delay", latch_cyc - fall_cyc, TmoC);
    check("s4_tmo", 32'(Timeout), 1);
    check("s4_ticks", n_tick - t_base, 0);
    check("s4_dist", 32'(Distance), 0);
    l_snap = n_latch;
    repeat (5) @(negedge Clk);
    Echo = 1'b0;
    repeat (5) @(negedge Clk);
    Echo = 1'b1;
    @(negedge Clk);
    Echo = 1'b0;
    repeat (10) @(negedge Clk);
    check("s4_glitch_dist", 32'(Distance), 0);
    check("s4_glitch_latch", n_latch - l_snap, 0);
    check("s4_glitch_tmo", 32'(Timeout), 1);
    check("s4_glitch_ticks", n_tick - t_base, 0);

    // Shot 5: Start dropped mid-MEASURE; 30-cycle echo -> 7 cm, then IDLE
    wait_sig(0, 1'b1, 420, "s5_trig_rise");
    wait_sig(0, 1'b0, 20, "s5_trig_fall");
    check("s5_period", last_rise - prev_rise, PeriodC);
    t_base = n_tick;
    repeat (3) @(negedge Clk);
    Echo = 1'b1;
    repeat (10) @(negedge Clk);
    Start = 1'b0;
    repeat (20) @(negedge Clk);
    echo_fall_latch("s5");
    check("s5_ticks", n_tick - t_base, 7);
    check("s5_dist", 32'(Distance), DistEn ? 7 : 0);
    r_snap = n_rise;
    wait_sig(2, 1'b0, 450, "s5_idle");
    repeat (50) @(negedge Clk);
    check("s5_no_retrig", n_rise - r_snap, 0);
    check("s5_busy", 32'(Busy), 0);
    check("s5_dist_hold", 32'(Distance), DistEn ? 7 : 0);

    // Shot 6: reset mid-MEASURE aborts without Latch; restart clears again
    Start = 1'b1;
    check_clear("s6");
    wait_sig(0, 1'b0, 20, "s6_trig_fall");
    repeat (3) @(negedge Clk);
    Echo = 1'b1;
    repeat (15) @(negedge Clk);
    l_snap = n_latch;
    nReset = 1'b0;
    @(negedge Clk);
    check_reset("s6_rst");
    Echo = 1'b0;
    nReset = 1'b1;
    check_clear("s6r");
    check("s6_no_latch", n_latch - l_snap, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/telemetre_sequencer.md
# telemetre_sequencer

Measurement sequencer for the ultrasonic telemeter. It fires the sensor trigger, times the echo pulse, and emits one count tick per centimetre of echo. Those ticks drive the cascaded modulo-10 up/down digit counters directly. It also clears the counter chain before each shot and pulses a latch strobe for the display register when the result is final.

## Interface
Parameters:
- TRIG_CYCLES, 500: trigger pulse width in Clk cycles (10 µs @ 50 MHz).
- CM_CYCLES, 2900: Clk cycles of echo per centimetre (58 µs).
- TIMEOUT_CYCLES, 1500000: maximum wait for echo rise, and maximum echo duration (30 ms).
- PERIOD_CYCLES, 3000000: minimum interval between trigger starts (60 ms).
- MAX_CM, 400: saturation distance in cm.

Ports:
- Clk  in  1  system clock; all logic on rising edge.
- nReset  in  1  reset, synchronous, active-low.
- Start  in  1  level; high = continuous measurement.
- Echo  in  1  sensor echo, asynchronous.
- Trig  out  1  sensor trigger pulse.
- CntTick  out  1  one-Clk-cycle pulse per cm; the digit counters act on its falling edge.
- CntClr_n  out  1  active-low clear for the digit counter chain.
- Latch  out  1  one-cycle strobe; result final.
- Busy  out  1  high in any state other than IDLE.
- Timeout  out  1  last shot had no echo, or the echo was too long; valid from Latch.
- Overrange  out  1  last shot reached MAX_CM; valid from Latch.
- Distance  out  $clog2(MAX_CM+1)  binary cm of last shot (see Configuration).

## Operation
States and transitions:
- IDLE: Start=1 -> CLEAR.
- CLEAR: 2 cycles. CntClr_n=0 throughout, with one CntTick in the second cycle so the counters' synchronous clear takes effect. Then -> TRIG.
- TRIG: Trig=1 for TRIG_CYCLES, then -> WAIT_ECHO.
- WAIT_ECHO: on synchronised rising edge of Echo -> MEASURE. If TIMEOUT_CYCLES elapse with no rise, set Timeout and go -> DONE.
- MEASURE: a prescaler counts Clk cycles and issues CntTick each time it reaches CM_CYCLES-1, then wraps to 0.
  - Echo falling edge -> DONE. A partial centimetre is truncated.
  - When ticks reach MAX_CM: no further ticks, Overrange=1, stay in MEASURE until the echo falls.
  - Echo still high TIMEOUT_CYCLES after its rise -> Timeout=1, -> DONE.
- DONE: Latch=1 for 1 cycle, then -> HOLDOFF.
- HOLDOFF: wait until PERIOD_CYCLES have elapsed since TRIG entry. Then -> CLEAR if Start=1, else -> IDLE.

Rules and boundary conditions:
- Timeout and Overrange clear on CLEAR entry. They hold their value from Latch until the next CLEAR.
- Start is sampled only in IDLE and at the end of HOLDOFF. Dropping Start mid-shot completes the shot.
- Echo already high when WAIT_ECHO is entered does not count; a rising edge is required. A stuck-high echo yields Timeout.
- Echo glitches during CLEAR, TRIG or HOLDOFF are ignored.
- nReset low in any state -> IDLE on the next edge; the shot is aborted and no Latch is issued.
- Reset values: Trig=0, CntTick=0, CntClr_n=1, Latch=0, Busy=0, Timeout=0, Overrange=0, Distance=0.

## Timing
- Echo passes through a 2-flop synchroniser plus an edge register. The edge is seen 3 cycles after the pin changes.
- First CntTick comes CM_CYCLES cycles after the rising edge is detected. A tick lasts 1 cycle, and ticks are never back-to-back (CM_CYCLES ≥ 2 required).
- Latch is asserted the cycle after the falling edge is detected. The final CntTick precedes Latch by at least 1 cycle.
- Trig is high for exactly TRIG_CYCLES cycles.
- Counter widths are $clog2 of each parameter. The timeout counter restarts on WAIT_ECHO entry and again on MEASURE entry.

## Configuration
- TELEMETRE_BIN_DIST_EN defined: an internal saturating binary cm counter is included.
  - It clears in CLEAR and increments with each CntTick.
  - Distance is updated on Latch and holds until the next Latch.
- Not defined: that counter is absent and Distance is tied to 0. All other behaviour is identical.

## Structure
- Shared package telemetre_pkg holds:
  - the state enum (IDLE, CLEAR, TRIG, WAIT_ECHO, MEASURE, DONE, HOLDOFF);
  - default timing constants for the 50 MHz board.
- Sub-module echo_sync: 2-flop synchroniser with rise and fall one-cycle pulse outputs.

## Test plan
All scenarios use TRIG_CYCLES=5, CM_CYCLES=4, TIMEOUT_CYCLES=200, PERIOD_CYCLES=400, MAX_CM=20.
- Start=1; Echo rises 10 cycles after Trig falls and lasts 50 cycles -> Trig high 5 cycles, 12 CntTick, Latch once, Distance=12, flags 0.
- Echo never rises -> Latch 200 cycles after Trig falls, Timeout=1, 0 CntTick, Distance=0.
- Echo held 120 cycles -> exactly 20 CntTick, Overrange=1, Distance=20, Latch follows the echo fall.
- Echo high before Trig and held -> Timeout=1 and no ticks. A glitch in HOLDOFF does not alter Distance.
- Continuous Start -> successive Trig rising edges are exactly 400 cycles apart. Start dropped mid-MEASURE -> Latch still issued, then IDLE with Busy=0.
- nReset pulsed low mid-MEASURE -> next cycle all outputs at reset values, no Latch. Shot restarts with CLEAR (CntClr_n low 2 cycles, 1 CntTick).
